run_pause_ctrl: RTL and testbench



---
 rtl/run_pause_pkg.sv | 20 ++
 rtl/run_pause_ctrl_lap_timer.sv | 38 +++
 rtl/run_pause_ctrl.sv | 127 ++++++++++++
 tb/tb_run_pause_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/run_pause_pkg.sv
// Shared state encoding and default timing constants for the run/pause sequencer.
package run_pause_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam int DEF_SEQ_LEN    = 6;
  localparam int DEF_EVEN_STEPS = 3;
  localparam int DEF_RUN_LAPS   = 3;
  localparam int DEF_PAUSE_LAPS = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/run_pause_ctrl_lap_timer.sv
// lap_timer: step counter wrapping at SEQ_LEN with a lap counter that advances on each wrap.
module lap_timer #(
  parameter int SEQ_LEN = 6,
  parameter int STEP_W  = 3,
  parameter int LAP_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  input  logic [LAP_W-1:0]  lap_limit,
  output logic [STEP_W-1:0] step,
  output logic [LAP_W-1:0]  lap,
  output logic              lap_wrap,
  output logic              last
);

  assign lap_wrap = (step == STEP_W'(SEQ_LEN - 1));
  assign last     = lap_wrap && (lap == (lap_limit - LAP_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step <= '0;
      lap  <= '0;
    end else if (clr) begin
      step <= '0;
      lap  <= '0;
    end else if (adv) begin
      if (lap_wrap) begin
        step <= '0;
        lap  <= lap + LAP_W'(1);
      end else begin
        step <= step + STEP_W'(1);
      end
    end
  end

endmodule

// File: rtl/run_pause_ctrl.sv
// Run/pause sequencer for the 0-2-4-5-7-9 counter: registered cnt_en/oe/cnt_clr replace clock gating.
// Optional PROG_LAPS_EN adds run_laps_i/pause_laps_i, latched at start, with 0 treated as 1.
//
//   state | meaning
//   IDLE  | waiting for start, counter untouched
//   CLEAR | one-cycle synchronous clear of the counter
//   RUN   | counter enabled for the run laps
//   PAUSE | counter held for the pause laps, then repeat or finish
module run_pause_ctrl
  import run_pause_pkg::*;
#(
  parameter int SEQ_LEN    = DEF_SEQ_LEN,
  parameter int EVEN_STEPS = DEF_EVEN_STEPS,
  parameter int RUN_LAPS   = DEF_RUN_LAPS,
  parameter int PAUSE_LAPS = DEF_PAUSE_LAPS,
`ifdef PROG_LAPS_EN
  localparam int LAP_W     = 4,
`else
  localparam int LAP_W     = $clog2(max_int(RUN_LAPS, PAUSE_LAPS) + 1),
`endif
  localparam int STEP_W    = $clog2(SEQ_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              repeat_i,
`ifdef PROG_LAPS_EN
  input  logic [3:0]        run_laps_i,
  input  logic [3:0]        pause_laps_i,
`endif
  output logic              cnt_en,
  output logic              oe,
  output logic              cnt_clr,
  output logic [STEP_W-1:0] step,
  output logic [LAP_W-1:0]  lap,
  output logic              busy,
  output logic              paused,
  output logic              done
);

  state_t             state, state_nxt;
  logic [LAP_W-1:0]   run_lim, pause_lim, lap_limit;
  logic [STEP_W-1:0]  step_nxt;
  logic               running, tmr_clr, tmr_adv, lap_wrap, last, done_nxt;

`ifdef PROG_LAPS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_lim   <= 4'd1;
      pause_lim <= 4'd1;
    end else if (state == IDLE && start && !stop) begin
      run_lim   <= (run_laps_i == 4'd0)   ? 4'd1 : run_laps_i;
      pause_lim <= (pause_laps_i == 4'd0) ? 4'd1 : pause_laps_i;
    end
  end
`else
  assign run_lim   = LAP_W'(RUN_LAPS);
  assign pause_lim = LAP_W'(PAUSE_LAPS);
`endif

  assign lap_limit = (state == PAUSE) ? pause_lim : run_lim;

  lap_timer #(
    .SEQ_LEN (SEQ_LEN),
    .STEP_W  (STEP_W),
    .LAP_W   (LAP_W)
  ) u_lap_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (tmr_clr),
    .adv       (tmr_adv),
    .lap_limit (lap_limit),
    .step      (step),
    .lap       (lap),
    .lap_wrap  (lap_wrap),
    .last      (last)
  );

  always_comb begin
    state_nxt = state;
    running   = (state == RUN) || (state == PAUSE);
    tmr_adv   = running;
    tmr_clr   = !running || stop || last;
    done_nxt  = 1'b0;
    case (state)
      IDLE:  if (start && !stop) state_nxt = CLEAR;
      CLEAR: state_nxt = stop ? IDLE : RUN;
      RUN: begin
        if (stop)      state_nxt = IDLE;
        else if (last) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = repeat_i ? RUN : IDLE;
          done_nxt  = !repeat_i;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Mirror the timer's next value so oe is registered alongside step.
    step_nxt = (tmr_clr || lap_wrap) ? '0 : step + STEP_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt_en  <= 1'b0;
      oe      <= 1'b0;
      cnt_clr <= 1'b0;
      busy    <= 1'b0;
      paused  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt_en  <= (state_nxt == RUN);
      oe      <= (state_nxt == RUN) && (step_nxt >= STEP_W'(EVEN_STEPS));
      cnt_clr <= (state_nxt == CLEAR);
      busy    <= (state_nxt != IDLE);
      paused  <= (state_nxt == PAUSE);
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_run_pause_ctrl.sv
// Randomized and directed bench for run_pause_ctrl against a phase/elapsed-time reference model.
module tb_run_pause_ctrl;
  import run_pause_pkg::*;

  localparam int SEQ_LEN    = DEF_SEQ_LEN;
  localparam int EVEN_STEPS = DEF_EVEN_STEPS;
  localparam int STEP_W     = $clog2(SEQ_LEN);
`ifdef PROG_LAPS_EN
  localparam int LAP_W      = 4;
`else
  localparam int LAP_W      = $clog2(max_int(DEF_RUN_LAPS, DEF_PAUSE_LAPS) + 1);
`endif

  localparam int M_IDLE = 0, M_CLEAR = 1, M_RUN = 2, M_PAUSE = 3;

  logic clk = 1'b0;
  logic reset, start, stop, repeat_i;
`ifdef PROG_LAPS_EN
  logic [3:0] run_laps_i, pause_laps_i;
`endif
  logic              cnt_en, oe, cnt_clr, busy, paused, done;
  logic [STEP_W-1:0] step;
  logic [LAP_W-1:0]  lap;

  always #5 clk = ~clk;

  run_pause_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .repeat_i     (repeat_i),
`ifdef PROG_LAPS_EN
    .run_laps_i   (run_laps_i),
    .pause_laps_i (pause_laps_i),
`endif
    .cnt_en       (cnt_en),
    .oe           (oe),
    .cnt_clr      (cnt_clr),
    .step         (step),
    .lap          (lap),
    .busy         (busy),
    .paused       (paused),
    .done         (done)
  );

  // Counter attached to the control outputs; deliberately has no reset.
  int seq_val [SEQ_LEN] = '{0, 2, 4, 5, 7, 9};
  int cnt_idx = 0;
  always @(posedge clk) begin
    if (cnt_clr)     cnt_idx <= 0;
    else if (cnt_en) cnt_idx <= (cnt_idx + 1) % SEQ_LEN;
  end

  int checks = 0;
  int errors = 0;
  int m_mode = M_IDLE;
  int m_t = 0;
  int m_done = 0;
  int m_run_laps = DEF_RUN_LAPS;
  int m_pause_laps = DEF_PAUSE_LAPS;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_t    = 0;
    m_done = 0;
  endtask

  task automatic model_edge(input logic s, input logic p, input logic r);
    m_done = 0;
    case (m_mode)
      M_IDLE: if (s && !p) begin
        m_mode = M_CLEAR;
`ifdef PROG_LAPS_EN
        m_run_laps   = (run_laps_i == 0) ? 1 : int'(run_laps_i);
        m_pause_laps = (pause_laps_i == 0) ? 1 : int'(pause_laps_i);
`endif
      end
      M_CLEAR: begin
        m_mode = p ? M_IDLE : M_RUN;
        m_t = 0;
      end
      M_RUN: begin
        if (p) m_mode = M_IDLE;
        else if (m_t == m_run_laps * SEQ_LEN - 1) begin m_mode = M_PAUSE; m_t = 0; end
        else m_t++;
      end
      default: begin
        if (p) m_mode = M_IDLE;
        else if (m_t == m_pause_laps * SEQ_LEN - 1) begin
          m_t = 0;
          if (r) m_mode = M_RUN;
          else begin m_mode = M_IDLE; m_done = 1; end
        end else m_t++;
      end
    endcase
    if (m_mode == M_IDLE || m_mode == M_CLEAR) m_t = 0;
  endtask

  task automatic check_outputs();
    int act;
    act = (m_mode == M_RUN || m_mode == M_PAUSE) ? 1 : 0;
    chk("cnt_clr", int'(cnt_clr), (m_mode == M_CLEAR) ? 1 : 0);
    chk("cnt_en",  int'(cnt_en),  (m_mode == M_RUN) ? 1 : 0);
    chk("oe",      int'(oe),      (m_mode == M_RUN && (m_t % SEQ_LEN) >= EVEN_STEPS) ? 1 : 0);
    chk("step",    int'(step),    act ? (m_t % SEQ_LEN) : 0);
    chk("lap",     int'(lap),     act ? (m_t / SEQ_LEN) : 0);
    chk("busy",    int'(busy),    (m_mode != M_IDLE) ? 1 : 0);
    chk("paused",  int'(paused),  (m_mode == M_PAUSE) ? 1 : 0);
    chk("done",    int'(done),    m_done);
    if (m_mode == M_RUN)   chk("counter_run",   seq_val[cnt_idx], seq_val[m_t % SEQ_LEN]);
    if (m_mode == M_PAUSE) chk("counter_pause", seq_val[cnt_idx], 0);
  endtask

  task automatic tick(input logic s, input logic p, input logic r);
    start = s; stop = p; repeat_i = r;
    @(posedge clk);
    model_edge(s, p, r);
    #1;
    check_outputs();
  endtask

  task automatic wait_for(input int mode, input int t, input logic r, input int budget);
    int n = 0;
    while (!(m_mode == mode && m_t == t) && n < budget) begin
      tick(1'b0, 1'b0, r);
      n++;
    end
    if (n >= budget) chk("wait_timeout", n, -1);
  endtask

  int clr_seen;
  int done_seen;
  logic rnd_rep;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; repeat_i = 1'b0;
`ifdef PROG_LAPS_EN
    run_laps_i = 4'd3; pause_laps_i = 4'd2;
`endif
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    reset = 1'b0;

    // Single pass, no repeat: clear, 18 run, 12 pause, done.
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 34; i++) tick(1'b0, 1'b0, 1'b0);

    // Repeat held: exactly one clear pulse, no done over three periods.
    clr_seen = 0; done_seen = 0;
    tick(1'b1, 1'b0, 1'b1);
    clr_seen += int'(cnt_clr);
    for (int i = 0; i < 95; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      clr_seen += int'(cnt_clr);
      done_seen += int'(done);
    end
    chk("repeat_clr_pulses", clr_seen, 1);
    chk("repeat_no_done", done_seen, 0);
    wait_for(M_IDLE, 0, 1'b0, 40);
    tick(1'b0, 1'b0, 1'b0);

    // Stop at step 4 of lap 2, restart two cycles later.
    tick(1'b1, 1'b0, 1'b0);
    wait_for(M_RUN, 2 * SEQ_LEN + 4, 1'b0, 40);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("restart_clear", int'(cnt_clr), 1);
    for (int i = 0; i < 35; i++) tick(1'b0, 1'b0, 1'b0);

    // start and stop together in IDLE.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);

    // start during PAUSE is ignored.
    tick(1'b1, 1'b0, 1'b0);
    wait_for(M_PAUSE, 2, 1'b0, 40);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN at step 3, lap 1.
    tick(1'b1, 1'b0, 1'b0);
    wait_for(M_RUN, SEQ_LEN + 3, 1'b0, 40);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

`ifdef PROG_LAPS_EN
    run_laps_i = 4'd1; pause_laps_i = 4'd0;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) tick(1'b0, 1'b0, 1'b0);
`endif

    // Randomized traffic.
    rnd_rep = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rnd_rep = ~rnd_rep;
`ifdef PROG_LAPS_EN
      run_laps_i   = 4'($urandom_range(0, 3));
      pause_laps_i = 4'($urandom_range(0, 3));
`endif
      tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0), rnd_rep);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
